// File: rtl/dff_err_frame_tx.sv
// Framed serial readout of the DFF error counters.
// Snapshot on save_data, shift one bit per data_clk edge, CRC-8 trailer.
module dff_err_frame_tx #(
  parameter int         N_CH   = 20,
  parameter int         CNT_W  = 12,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_CH*CNT_W-1:0]   ERR_CNT_FLAT,
  input  logic                    save_data,
  input  logic                    data_clk,
  output logic                    DATA_OUT,
  output logic                    BUSY,
  output logic                    FRAME_DONE,
  output logic                    OVERRUN
);

  localparam int PRE_BITS   = 16 + N_CH * CNT_W;
  localparam int FRAME_BITS = PRE_BITS + 8;
  localparam int IDX_W      = 9;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [2:0]            save_sr;
  logic [2:0]            dclk_sr;
  logic [N_CH*CNT_W-1:0] shadow;
  logic [7:0]            crc;
  logic [IDX_W-1:0]      idx;

  logic                  save_edge;
  logic                  dclk_edge;
  logic [PRE_BITS-1:0]   pre;
  logic [FRAME_BITS-1:0] frame_now;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [IDX_W-1:0]      rev_cur;
  logic [IDX_W-1:0]      rev_nxt;
  logic                  cur_bit;
  logic                  crc_fb;
  logic [7:0]            crc_nxt;

  assign save_edge = save_sr[1] & ~save_sr[2];
  assign dclk_edge = dclk_sr[1] & ~dclk_sr[2];

  // Frame laid out MSB-first so bit index k lives at position FRAME_BITS-1-k
  always_comb begin
    pre = '0;
    pre[PRE_BITS-1 -: 16] = {HEADER, 8'(N_CH)};
    for (int i = 0; i < N_CH; i++) begin
      pre[PRE_BITS-17-i*CNT_W -: CNT_W] = shadow[i*CNT_W +: CNT_W];
    end
  end

  assign idx_nxt   = idx + IDX_W'(1);
  assign rev_cur   = IDX_W'(FRAME_BITS - 1) - idx;
  assign rev_nxt   = IDX_W'(FRAME_BITS - 1) - idx_nxt;
  assign frame_now = {pre, crc};
  assign cur_bit   = frame_now[rev_cur];
  assign crc_fb    = crc[7] ^ cur_bit;

  always_comb begin
    crc_nxt = crc;
    if (idx < IDX_W'(PRE_BITS)) begin
      crc_nxt = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  assign frame_nxt = {pre, crc_nxt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      save_sr    <= '0;
      dclk_sr    <= '0;
      shadow     <= '0;
      crc        <= '0;
      idx        <= '0;
      DATA_OUT   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      save_sr    <= {save_sr[1:0], save_data};
      dclk_sr    <= {dclk_sr[1:0], data_clk};
      FRAME_DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // a coincident data_clk edge is dropped so bit 0 is not skipped
          if (save_edge) begin
            shadow   <= ERR_CNT_FLAT;
            crc      <= '0;
            idx      <= '0;
            OVERRUN  <= 1'b0;
            BUSY     <= 1'b1;
            DATA_OUT <= HEADER[7];
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (save_edge) OVERRUN <= 1'b1;
          if (dclk_edge) begin
            idx <= idx_nxt;
            crc <= crc_nxt;
            if (idx_nxt == IDX_W'(FRAME_BITS)) begin
              state      <= S_DONE;
              BUSY       <= 1'b0;
              FRAME_DONE <= 1'b1;
              DATA_OUT   <= 1'b0;
            end else begin
              DATA_OUT <= frame_nxt[rev_nxt];
            end
          end
        end
        S_DONE: begin
          BUSY     <= 1'b0;
          DATA_OUT <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_err_frame_tx.sv
// Randomized bench for dff_err_frame_tx.
// Frames are rebuilt and CRC'd bytewise by a reference model.
module tb_dff_err_frame_tx;

  localparam int N_CH = 20;
  localparam int CNT_W = 12;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH*CNT_W-1:0] err_cnt_flat = '0;
  logic                  save_data = 1'b0;
  logic                  data_clk = 1'b0;
  logic                  data_out;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_busy = 0;

  logic [11:0]  cnt [N_CH];
  logic [263:0] exp_f;
  logic [263:0] rx;

  dff_err_frame_tx dut (
    .CLK         (clk),
    .RST         (rst),
    .ERR_CNT_FLAT(err_cnt_flat),
    .save_data   (save_data),
    .data_clk    (data_clk),
    .DATA_OUT    (data_out),
    .BUSY        (busy),
    .FRAME_DONE  (frame_done),
    .OVERRUN     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_done && busy) done_busy++;
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_dclk();
    data_clk = 1'b1;
    repeat (4) tick();
    data_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_save();
    save_data = 1'b1;
    repeat (4) tick();
    save_data = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load_counts();
    for (int i = 0; i < N_CH; i++) err_cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  endtask

  // Reference frame: header, channel count, counts, bytewise CRC-8/0x07
  task automatic model();
    logic [255:0] pre;
    logic [7:0]   c;
    pre = '0;
    pre[255 -: 16] = {8'hA5, 8'd20};
    for (int i = 0; i < N_CH; i++) pre[239 - 12*i -: 12] = cnt[i];
    c = 8'h00;
    for (int k = 0; k < 32; k++) begin
      c = c ^ pre[255 - 8*k -: 8];
      for (int b = 0; b < 8; b++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    exp_f = {pre, c};
  endtask

  // act: 0 none, 1 zero live counts, 2 save pulse, 3 reset
  task automatic rx_frame(input string tag, input int act_at, input int act);
    int d0;
    int busy_bad;
    busy_bad = 0;
    d0 = done_cnt;
    rx = '0;
    for (int i = 0; i < 264; i++) begin
      if (i == act_at && act == 1) err_cnt_flat = '0;
      if (i == act_at && act == 2) pulse_save();
      if (i == act_at && act == 3) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_rst_out"}, 256'(data_out), 256'(0));
        chk({tag, "_rst_busy"}, 256'(busy), 256'(0));
        chk({tag, "_rst_ovr"}, 256'(overrun), 256'(0));
        return;
      end
      rx[263 - i] = data_out;
      if (busy !== 1'b1) busy_bad++;
      pulse_dclk();
    end
    repeat (3) tick();
    chk({tag, "_hdr"}, 256'(rx[263:248]), 256'(exp_f[263:248]));
    chk({tag, "_pay"}, 256'(rx[247:8]), 256'(exp_f[247:8]));
    chk({tag, "_crc"}, 256'(rx[7:0]), 256'(exp_f[7:0]));
    chk({tag, "_busy_in"}, 256'(busy_bad), 256'(0));
    chk({tag, "_done"}, 256'(done_cnt - d0), 256'(1));
    chk({tag, "_busy_end"}, 256'(busy), 256'(0));
    chk({tag, "_out_end"}, 256'(data_out), 256'(0));
  endtask

  task automatic start_frame(input string tag);
    load_counts();
    model();
    pulse_save();
    chk({tag, "_b0"}, 256'(data_out), 256'(1));
    chk({tag, "_busy0"}, 256'(busy), 256'(1));
  endtask

  initial begin
    int bad;
    repeat (3) tick();
    chk("rst_out", 256'(data_out), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(frame_done), 256'(0));
    chk("rst_ovr", 256'(overrun), 256'(0));
    rst = 1'b0;
    tick();

    bad = 0;
    for (int k = 0; k < 10; k++) begin
      pulse_dclk();
      if (data_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("idle_quiet", 256'(bad), 256'(0));
    chk("idle_done", 256'(done_cnt), 256'(0));

    for (int i = 0; i < N_CH; i++) cnt[i] = 12'h100 + 12'(i);
    start_frame("inc");
    rx_frame("inc", -1, 0);
    chk("inc_first16", 256'(rx[263:248]), 256'(16'hA514));
    chk("inc_ch0", 256'(rx[247:236]), 256'(12'h100));

    for (int i = 0; i < N_CH; i++) cnt[i] = 12'hFFF;
    start_frame("ones");
    rx_frame("ones", 100, 1);
    chk("ones_pay", 256'(rx[247:8]), {16'h0, {240{1'b1}}});

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_CH; i++) cnt[i] = 12'($urandom_range(0, 4095));
      start_frame("rnd");
      rx_frame("rnd", -1, 0);
    end

    for (int i = 0; i < N_CH; i++) cnt[i] = 12'($urandom_range(0, 4095));
    start_frame("ovr");
    rx_frame("ovr", 50, 2);
    chk("ovr_flag", 256'(overrun), 256'(1));

    for (int i = 0; i < N_CH; i++) cnt[i] = 12'($urandom_range(0, 4095));
    load_counts();
    model();
    save_data = 1'b1;
    data_clk = 1'b1;
    repeat (4) tick();
    save_data = 1'b0;
    data_clk = 1'b0;
    repeat (4) tick();
    chk("same_b0", 256'(data_out), 256'(1));
    chk("same_ovr", 256'(overrun), 256'(0));
    pulse_dclk();
    chk("same_b1", 256'(data_out), 256'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < N_CH; i++) cnt[i] = 12'($urandom_range(0, 4095));
    start_frame("abort");
    rx_frame("abort", 120, 3);
    tick();
    start_frame("fresh");
    rx_frame("fresh", -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dff_err_frame_tx.md
# dff_err_frame_tx

Framed serial readout stage for the DFF error counters. It snapshots all per-chain 12-bit error counts on a Raspberry Pi save request and shifts them out one bit per Pi data-clock edge. Each frame carries a header, a channel count, the payload and a CRC-8. It sits directly downstream of the per-chain error counters (chip 0 chains 0–9, then chip 1 chains 0–9) and drives the Pi's DFF data-out pin.

## Interface
- N_CH, 20, number of counter channels in the frame
- CNT_W, 12, width of each error count
- HEADER, 8'hA5, frame start byte
- CLK  in  1  system clock (CLK_MUXOUT domain)
- RST  in  1  synchronous, active-high reset
- ERR_CNT_FLAT  in  N_CH*CNT_W  packed counts; channel i = bits [i*CNT_W +: CNT_W]; chip 0 chain 0 is channel 0, chip 1 chain 9 is channel 19
- save_data  in  1  Pi snapshot request, asynchronous to CLK
- data_clk  in  1  Pi bit clock, asynchronous to CLK
- DATA_OUT  out  1  current frame bit
- BUSY  out  1  frame in progress
- FRAME_DONE  out  1  one-cycle pulse after the last bit advances
- OVERRUN  out  1  sticky flag: save_data edge arrived while BUSY

## Operation
- save_data and data_clk each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync2_d).
- States:
  - IDLE: on a save edge, load a shadow register with ERR_CNT_FLAT, clear CRC to 8'h00, clear bit index, clear OVERRUN, set BUSY, go to SHIFT.
  - SHIFT: on each data_clk edge, advance the bit index by 1 and update the CRC with the departing bit, up to and including the last pre-CRC bit.
  - From SHIFT, when the edge retires bit FRAME_BITS-1: go to DONE.
  - DONE: pulse FRAME_DONE for one cycle, clear BUSY, drive DATA_OUT=0, return to IDLE.
- Frame bit order, MSB first within each field:
  - HEADER (8 bits)
  - N_CH as 8 bits
  - channel 0 … channel N_CH-1 (CNT_W bits each)
  - CRC-8 (8 bits)
- Field sizes: PRE_BITS = 16 + N_CH*CNT_W = 256; FRAME_BITS = PRE_BITS + 8 = 264. The 9-bit index does not wrap, and DONE is entered exactly at 264.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. It is computed serially over bits 0..PRE_BITS-1 and frozen at index PRE_BITS. Bits PRE_BITS..FRAME_BITS-1 output the frozen CRC, MSB first.
- DATA_OUT is registered. It equals frame bit [index] whenever BUSY, and 0 otherwise.
- Shadow register is held constant for the whole frame; live counter changes do not affect an in-flight frame.
- save edge while BUSY: ignored; OVERRUN set (sticky until the next accepted snapshot or RST).
- data_clk edge in IDLE or DONE: ignored.
- save edge and data_clk edge in the same IDLE cycle: the snapshot is taken and the data_clk edge is discarded, so bit 0 is not skipped.
- RST mid-frame: abort the frame; all state returns to reset values on that edge.

## Timing
- Reset values: DATA_OUT=0, BUSY=0, FRAME_DONE=0, OVERRUN=0, state IDLE, index 0, CRC 8'h00, synchronizers 0.
- Input high first sampled at CLK edge n: sync2 high after edge n+1, edge detect active in cycle n+1→n+2, action registered at edge n+2.
  - save: BUSY=1 and DATA_OUT = header bit 7 (1) after edge n+2.
  - data_clk: next bit on DATA_OUT after edge n+2.
- The Pi samples DATA_OUT before raising data_clk. data_clk high and low phases must each be ≥3 CLK periods; save_data high ≥3 CLK periods.
- The 264th data_clk edge leads to: DONE one cycle after its edge-registered action, FRAME_DONE high for exactly 1 cycle, BUSY low in the same cycle as FRAME_DONE.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: toggle data_clk 10× with no save -> DATA_OUT=0, BUSY=0 throughout; FRAME_DONE never pulses.
- Snapshot with channel i = 12'h100+i, then 264 data_clk pulses -> first 16 bits = 1010_0101 0001_0100; channel 0 bits = 0001_0000_0000; CRC byte matches bench model; exactly one FRAME_DONE; BUSY drops.
- Counts all 12'hFFF, and ERR_CNT_FLAT changed to 0 mid-frame -> payload is 240 ones (shadow held); CRC matches model.
- save pulse at bit index 50 -> frame continues unchanged; OVERRUN=1. Next accepted save -> OVERRUN=0.
- save and data_clk rising in the same CLK cycle from IDLE -> DATA_OUT = bit 0 (1) and index 0 after the snapshot. The next data_clk gives bit 1 (0).
- RST at bit index 120 -> the next cycle shows DATA_OUT=0, BUSY=0, OVERRUN=0. A fresh save + 264 clocks yields a complete, correct frame.
